// File: rtl/gf2_linear_solver_if.sv
// Stream and matrix-load bundle between the GF(2) inverter side, the solver and the
// downstream consumer of solution vectors.
interface gf2_linear_solver_if #(
  parameter int CNT_W = 8
);
  logic             mat_ld;
  logic [15:0]      mat_in;
  logic             in_vld;
  logic [3:0]       in_vec;
  logic             in_rdy;
  logic             out_vld;
  logic [3:0]       out_vec;
  logic             out_rdy;
  logic             mat_valid;
  logic [CNT_W-1:0] vec_cnt;

  modport master (
    output mat_ld, mat_in, in_vld, in_vec, out_rdy,
    input  in_rdy, out_vld, out_vec, mat_valid, vec_cnt
  );

  modport slave (
    input  mat_ld, mat_in, in_vld, in_vec, out_rdy,
    output in_rdy, out_vld, out_vec, mat_valid, vec_cnt
  );
endinterface

// File: rtl/gf2_linear_solver.sv
// Latches a 4x4 GF(2) matrix and computes x = M * b for each accepted vector b,
// buffering results in a 2-entry FIFO so input readiness is decoupled from out_rdy.
module gf2_linear_solver #(
  parameter int CNT_W = 8
) (
  input logic                i_clk,
  input logic                i_rst,
  gf2_linear_solver_if.slave bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_rdy;
  logic [15:0]      r_mat;
  logic [3:0]       r_ent0;
  logic [3:0]       r_ent1;
  logic [1:0]       r_occ;
  logic [CNT_W-1:0] r_vec_cnt;
  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_x;

  // Row r sits at m[15-4r -: 4]; x_r lands on bit 3-r, so bit3 carries x0.
  function automatic logic [3:0] gf2_mat_vec(input logic [15:0] m, input logic [3:0] v);
    logic [3:0] x;
    x = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      x[3-r] = ^(m[15-4*r -: 4] & v);
    end
    return x;
  endfunction

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and input readiness; a load cycle never accepts a vector.
  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (bus.mat_ld) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
        w_in_rdy    = !bus.mat_ld && (r_occ < 2'd2);
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_in_rdy    = 1'b0;
      end
    endcase
  end

  assign w_push = bus.in_vld && w_in_rdy;
  assign w_pop  = (r_occ != 2'd0) && bus.out_rdy;
  assign w_x    = gf2_mat_vec(r_mat, bus.in_vec);

  // Matrix register: result of a push in the load cycle is impossible, so old/new never mix.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mat <= 16'h0000;
    end else if (bus.mat_ld) begin
      r_mat <= bus.mat_in;
    end
  end

  // Shift FIFO: r_ent0 is the head and keeps its last value once the FIFO drains.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ent0 <= 4'b0000;
      r_ent1 <= 4'b0000;
      r_occ  <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_ent0 <= w_x;
          end else begin
            r_ent1 <= w_x;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          if (r_occ == 2'd2) begin
            r_ent0 <= r_ent1;
          end
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_ent0 <= w_x;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= w_x;
          end
        end
        default: begin
          r_occ <= r_occ;
        end
      endcase
    end
  end

  // Delivered-vector counter; a delivery coinciding with a load counts toward the new matrix.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vec_cnt <= {CNT_W{1'b0}};
    end else if (bus.mat_ld) begin
      r_vec_cnt <= w_pop ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (w_pop) begin
      r_vec_cnt <= r_vec_cnt + CNT_W'(1);
    end
  end

  assign bus.in_rdy    = w_in_rdy;
  assign bus.out_vld   = (r_occ != 2'd0);
  assign bus.out_vec   = r_ent0;
  assign bus.mat_valid = (r_state == ST_RUN);
  assign bus.vec_cnt   = r_vec_cnt;

endmodule

// File: tb/tb_gf2_linear_solver.sv
// Random and directed stimulus for gf2_linear_solver, checked cycle by cycle against a
// queue-based reference of the solver's visible behaviour.
module tb_gf2_linear_solver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gf2_linear_solver_if #(.CNT_W(8)) bus ();
  gf2_linear_solver #(.CNT_W(8)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [3:0]  mdl_q[$];
  logic [15:0] mdl_mat;
  bit          mdl_loaded;
  int          mdl_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Plain matrix-vector product mod 2 on an explicit 4x4 array.
  function automatic logic [3:0] ref_mul(input logic [15:0] m, input logic [3:0] b);
    int a [4][4];
    int bv [4];
    int s;
    logic [3:0] x;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = int'(m[15-4*r-c]);
    for (int c = 0; c < 4; c++) bv[c] = int'(b[3-c]);
    for (int r = 0; r < 4; r++) begin
      s = 0;
      for (int c = 0; c < 4; c++) s += a[r][c] * bv[c];
      x[3-r] = (s % 2) == 1;
    end
    return x;
  endfunction

  task automatic model_reset();
    mdl_q.delete();
    mdl_mat    = 16'h0000;
    mdl_loaded = 1'b0;
    mdl_cnt    = 0;
  endtask

  task automatic step(input logic ld, input logic [15:0] m, input logic v,
                      input logic [3:0] b, input logic ordy);
    bit exp_rdy, pop, push;
    logic [3:0] x;
    @(negedge clk);
    bus.mat_ld  = ld;
    bus.mat_in  = m;
    bus.in_vld  = v;
    bus.in_vec  = b;
    bus.out_rdy = ordy;
    #1;
    exp_rdy = mdl_loaded && !ld && (mdl_q.size() < 2);
    check("in_rdy", 32'(bus.in_rdy), 32'(exp_rdy));
    check("out_vld", 32'(bus.out_vld), 32'(mdl_q.size() != 0));
    if (mdl_q.size() != 0) check("out_vec", 32'(bus.out_vec), 32'(mdl_q[0]));
    check("vec_cnt", 32'(bus.vec_cnt), 32'(mdl_cnt));
    check("mat_valid", 32'(bus.mat_valid), 32'(mdl_loaded));
    pop  = (mdl_q.size() != 0) && ordy;
    push = exp_rdy && v;
    x    = ref_mul(mdl_mat, b);
    if (pop) void'(mdl_q.pop_front());
    if (push) mdl_q.push_back(x);
    if (ld) begin
      mdl_mat    = m;
      mdl_loaded = 1'b1;
      mdl_cnt    = pop ? 1 : 0;
    end else if (pop) begin
      mdl_cnt = (mdl_cnt + 1) % 256;
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.mat_ld  = 1'b0;
    bus.mat_in  = 16'h0000;
    bus.in_vld  = 1'b0;
    bus.in_vec  = 4'b0000;
    bus.out_rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
    check("rst_out_vld", 32'(bus.out_vld), 32'd0);
    check("rst_out_vec", 32'(bus.out_vec), 32'd0);
    check("rst_vec_cnt", 32'(bus.vec_cnt), 32'd0);
    check("rst_mat_valid", 32'(bus.mat_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // No matrix loaded: offered vectors must be refused.
    repeat (10) step(1'b0, 16'h0000, 1'b1, 4'b1111, 1'b1);

    // Identity matrix.
    step(1'b1, 16'h8421, 1'b1, 4'b1010, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 4'b1010, 1'b1);
    @(posedge clk); #1;
    check("ident_x", 32'(bus.out_vec), 32'h0000000a);
    step(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b1);
    @(posedge clk); #1;
    check("ident_cnt", 32'(bus.vec_cnt), 32'd1);

    // Non-identity matrix, back-to-back vectors.
    step(1'b1, 16'hC421, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 4'b0100, 1'b1);
    @(posedge clk); #1;
    check("c421_a", 32'(bus.out_vec), 32'h0000000c);
    step(1'b0, 16'h0000, 1'b1, 4'b1000, 1'b1);
    @(posedge clk); #1;
    check("c421_b", 32'(bus.out_vec), 32'h00000008);
    repeat (2) step(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b1);

    // Back-pressure: two accepted, third held off until the head drains.
    step(1'b1, 16'h8421, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 4'b0001, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 4'b0010, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 4'b0100, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 4'b0100, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 4'b0100, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 4'b0100, 1'b1);
    repeat (3) step(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b1);

    // Reload with two results buffered under the identity.
    step(1'b0, 16'h0000, 1'b1, 4'b1010, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 4'b0110, 1'b0);
    step(1'b1, 16'hC421, 1'b1, 4'b1111, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1, 4'b0100, 1'b1);
    repeat (2) step(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b1);

    // Asynchronous reset with the buffer full.
    step(1'b0, 16'h0000, 1'b1, 4'b0011, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 4'b0101, 1'b0);
    @(negedge clk);
    bus.in_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_vld", 32'(bus.out_vld), 32'd0);
    check("arst_mat_valid", 32'(bus.mat_valid), 32'd0);
    check("arst_vec_cnt", 32'(bus.vec_cnt), 32'd0);
    check("arst_in_rdy", 32'(bus.in_rdy), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step(1'b0, 16'h0000, 1'b1, 4'b1111, 1'b1);

    // Long stream through one matrix so vec_cnt wraps.
    step(1'b1, 16'h8421, 1'b0, 4'b0000, 1'b1);
    repeat (300) step(1'b0, 16'h0000, 1'b1, 4'($urandom), 1'b1);

    // Random matrices, vectors and back-pressure.
    step(1'b1, 16'($urandom), 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 49) == 0), 16'($urandom), 1'($urandom_range(0, 1)),
           4'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (3) step(1'b0, 16'h0000, 1'b0, 4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
